multicycle_ctrl: RTL and testbench

//  Multicycle MIPS control FSM: sequences IF/ID/EXE/MEM/WB and drives datapath controls from the current state and opcode.

---
 rtl/multicycle_ctrl_if.sv | 45 ++++
 rtl/multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the MIPS datapath.
// The controller uses the master side; the datapath uses the slave side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic             zero;
  logic             sign;
  logic             mem_ready;
  logic [2:0]       state;
  logic             PCWre;
  logic             IRWre;
  logic             RegWre;
  logic             mRD;
  logic             mWR;
  logic             ALUSrcA;
  logic             ALUSrcB;
  logic [2:0]       ALUOp;
  logic             ExtSel;
  logic [1:0]       RegDst;
  logic             WrRegDSrc;
  logic             DBDataSrc;
  logic [1:0]       PCSrc;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, zero, sign, mem_ready,
    output state, PCWre, IRWre, RegWre,
    output mRD, mWR, ALUSrcA, ALUSrcB,
    output ALUOp, ExtSel, RegDst,
    output WrRegDSrc, DBDataSrc, PCSrc,
    output halted, illegal, retired
  );

  modport slave (
    output op, zero, sign, mem_ready,
    input  state, PCWre, IRWre, RegWre,
    input  mRD, mWR, ALUSrcA, ALUSrcB,
    input  ALUOp, ExtSel, RegDst,
    input  WrRegDSrc, DBDataSrc, PCSrc,
    input  halted, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences IF/ID/EXE/MEM/WB and
// drives datapath controls from the current state and opcode.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic CLK,
  input  logic RST_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_BLTZ  = 6'b110010;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_t           st;
  state_t           nxt;
  logic             halted;
  logic [CNT_W-1:0] cnt;

  logic       is_alu;
  logic       is_imm;
  logic       is_sll;
  logic       is_sext;
  logic       is_br;
  logic       is_ls;
  logic       is_jmp;
  logic       is_halt;
  logic [2:0] alu_fn;
  logic       taken;

  always_comb begin
    is_alu  = 1'b0;
    is_imm  = 1'b0;
    is_sll  = 1'b0;
    is_sext = 1'b0;
    is_br   = 1'b0;
    is_ls   = 1'b0;
    is_jmp  = 1'b0;
    is_halt = 1'b0;
    alu_fn  = 3'b000;
    case (bus.op)
      OP_ADD:   is_alu = 1'b1;
      OP_SUB: begin
        is_alu = 1'b1;
        alu_fn = 3'b001;
      end
      OP_ADDIU: begin
        is_alu  = 1'b1;
        is_imm  = 1'b1;
        is_sext = 1'b1;
      end
      OP_ANDI: begin
        is_alu = 1'b1;
        is_imm = 1'b1;
        alu_fn = 3'b100;
      end
      OP_AND: begin
        is_alu = 1'b1;
        alu_fn = 3'b100;
      end
      OP_ORI: begin
        is_alu = 1'b1;
        is_imm = 1'b1;
        alu_fn = 3'b011;
      end
      OP_OR: begin
        is_alu = 1'b1;
        alu_fn = 3'b011;
      end
      OP_SLL: begin
        is_alu = 1'b1;
        is_sll = 1'b1;
        alu_fn = 3'b010;
      end
      OP_SLTI: begin
        is_alu  = 1'b1;
        is_imm  = 1'b1;
        is_sext = 1'b1;
        alu_fn  = 3'b101;
      end
      OP_SW, OP_LW:            is_ls   = 1'b1;
      OP_BEQ, OP_BNE, OP_BLTZ: is_br   = 1'b1;
      OP_J, OP_JR, OP_JAL:     is_jmp  = 1'b1;
      OP_HALT:                 is_halt = 1'b1;
      default: ;
    endcase
  end

  assign taken = (bus.op == OP_BEQ  &&  bus.zero) ||
                 (bus.op == OP_BNE  && !bus.zero) ||
                 (bus.op == OP_BLTZ &&  bus.sign);

  always_comb begin
    nxt           = st;
    bus.PCWre     = 1'b0;
    bus.IRWre     = 1'b0;
    bus.RegWre    = 1'b0;
    bus.mRD       = 1'b0;
    bus.mWR       = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 1'b0;
    bus.ALUOp     = 3'b000;
    bus.ExtSel    = 1'b0;
    bus.RegDst    = 2'b00;
    bus.WrRegDSrc = 1'b0;
    bus.DBDataSrc = 1'b0;
    bus.PCSrc     = 2'b00;
    bus.illegal   = 1'b0;
    case (st)
      S_IF: begin
        bus.IRWre = 1'b1;
        nxt       = S_ID;
      end
      S_ID: begin
        // once halted, ID is parked regardless of what op shows
        if (halted || is_halt) begin
          nxt = S_ID;
        end else if (is_jmp) begin
          bus.PCWre = 1'b1;
          bus.PCSrc = (bus.op == OP_JR) ? 2'b10 : 2'b11;
          if (bus.op == OP_JAL) begin
            bus.RegWre = 1'b1;
          end
          nxt = S_IF;
        end else if (is_br) begin
          nxt = S_EXE_BR;
        end else if (is_ls) begin
          nxt = S_EXE_LS;
        end else if (is_alu) begin
          nxt = S_EXE_AL;
        end else begin
          bus.illegal = 1'b1;
          bus.PCWre   = 1'b1;
          nxt         = S_IF;
        end
      end
      S_EXE_AL: begin
        bus.ALUOp   = alu_fn;
        bus.ALUSrcB = is_imm;
        bus.ALUSrcA = is_sll;
        bus.ExtSel  = is_sext;
        nxt         = S_WB_AL;
      end
      S_WB_AL: begin
        bus.RegWre    = 1'b1;
        bus.WrRegDSrc = 1'b1;
        bus.RegDst    = is_imm ? 2'b01 : 2'b10;
        bus.PCWre     = 1'b1;
        nxt           = S_IF;
      end
      S_EXE_BR: begin
        bus.ALUOp = (bus.op == OP_BLTZ) ? 3'b101 : 3'b001;
        bus.PCWre = 1'b1;
        bus.PCSrc = taken ? 2'b01 : 2'b00;
        nxt       = S_IF;
      end
      S_EXE_LS: begin
        bus.ALUSrcB = 1'b1;
        bus.ExtSel  = 1'b1;
        nxt         = S_MEM;
      end
      S_MEM: begin
        bus.mWR = (bus.op == OP_SW);
        bus.mRD = (bus.op == OP_LW);
        if (bus.mem_ready) begin
          if (bus.op == OP_SW) begin
            bus.PCWre = 1'b1;
            nxt       = S_IF;
          end else begin
            nxt = S_WB_LD;
          end
        end
      end
      S_WB_LD: begin
        bus.RegWre    = 1'b1;
        bus.RegDst    = 2'b01;
        bus.WrRegDSrc = 1'b1;
        bus.DBDataSrc = 1'b1;
        bus.PCWre     = 1'b1;
        nxt           = S_IF;
      end
      default: nxt = S_IF;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      st     <= S_IF;
      halted <= 1'b0;
      cnt    <= '0;
    end else begin
      st <= nxt;
      if (st == S_ID && is_halt) begin
        halted <= 1'b1;
      end
      // a skipped illegal opcode moves the PC but is not retired
      if (bus.PCWre && !bus.illegal) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.state   = st;
  assign bus.halted  = halted;
  assign bus.retired = cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-level bench for multicycle_ctrl with an
// instruction-path reference model and per-cycle output comparison.
module tb_multicycle_ctrl;

  localparam int W = 4;

  typedef enum int {
    C_R, C_I, C_BR, C_SW, C_LW, C_J, C_JR, C_JAL, C_HALT, C_BAD
  } cls_t;

  typedef struct packed {
    logic [2:0]   state;
    logic         PCWre;
    logic         IRWre;
    logic         RegWre;
    logic         mRD;
    logic         mWR;
    logic         ALUSrcA;
    logic         ALUSrcB;
    logic [2:0]   ALUOp;
    logic         ExtSel;
    logic [1:0]   RegDst;
    logic         WrRegDSrc;
    logic         DBDataSrc;
    logic [1:0]   PCSrc;
    logic         halted;
    logic         illegal;
    logic [W-1:0] retired;
  } exp_t;

  logic CLK;
  logic RST_n;

  multicycle_ctrl_if #(.CNT_W(W)) bus ();

  multicycle_ctrl #(.CNT_W(W)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  exp_t         exp_cur;
  logic         exp_valid;
  logic [W-1:0] m_ret;
  logic         m_halt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic cls_t classify(input logic [5:0] o);
    case (o)
      6'b000000, 6'b000001, 6'b010001,
      6'b010011, 6'b011000:            return C_R;
      6'b000010, 6'b010000, 6'b010010,
      6'b011100:                       return C_I;
      6'b110000, 6'b110001, 6'b110010: return C_BR;
      6'b100110:                       return C_SW;
      6'b100111:                       return C_LW;
      6'b111000:                       return C_J;
      6'b111001:                       return C_JR;
      6'b111010:                       return C_JAL;
      6'b111111:                       return C_HALT;
      default:                         return C_BAD;
    endcase
  endfunction

  // mnemonic -> ALU function: add/addiu, sub, sll, or/ori, and/andi, slti
  function automatic logic [2:0] alu_code(input logic [5:0] o);
    case (o)
      6'b000001:            return 3'd1;
      6'b011000:            return 3'd2;
      6'b010011, 6'b010010: return 3'd3;
      6'b010001, 6'b010000: return 3'd4;
      6'b011100:            return 3'd5;
      default:              return 3'd0;
    endcase
  endfunction

  function automatic exp_t mk(input logic [2:0] st);
    exp_t e;
    e         = '0;
    e.state   = st;
    e.retired = m_ret;
    e.halted  = m_halt;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (exp_valid) begin
      exp_t a;
      a.state     = bus.state;
      a.PCWre     = bus.PCWre;
      a.IRWre     = bus.IRWre;
      a.RegWre    = bus.RegWre;
      a.mRD       = bus.mRD;
      a.mWR       = bus.mWR;
      a.ALUSrcA   = bus.ALUSrcA;
      a.ALUSrcB   = bus.ALUSrcB;
      a.ALUOp     = bus.ALUOp;
      a.ExtSel    = bus.ExtSel;
      a.RegDst    = bus.RegDst;
      a.WrRegDSrc = bus.WrRegDSrc;
      a.DBDataSrc = bus.DBDataSrc;
      a.PCSrc     = bus.PCSrc;
      a.halted    = bus.halted;
      a.illegal   = bus.illegal;
      a.retired   = bus.retired;
      chk("cycle", 32'(a), 32'(exp_cur));
    end
  end

  task automatic cyc(input exp_t e, input logic [5:0] o,
                     input logic z, input logic s, input logic rdy);
    bus.op        = o;
    bus.zero      = z;
    bus.sign      = s;
    bus.mem_ready = rdy;
    exp_cur       = e;
    exp_valid     = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // zf/sf: -1 random, else forced flag value for the branch cycle
  task automatic exec(input logic [5:0] o, input int waits,
                      input int zf, input int sf);
    exp_t e;
    cls_t c;
    logic z, s, tk;
    c = classify(o);
    e = mk(3'd0);
    e.IRWre = 1'b1;
    cyc(e, o, rb(), rb(), rb());
    e = mk(3'd1);
    case (c)
      C_J, C_JR, C_JAL: begin
        e.PCWre  = 1'b1;
        e.PCSrc  = (c == C_JR) ? 2'b10 : 2'b11;
        e.RegWre = (c == C_JAL);
        cyc(e, o, rb(), rb(), rb());
        m_ret++;
      end
      C_BAD: begin
        e.illegal = 1'b1;
        e.PCWre   = 1'b1;
        cyc(e, o, rb(), rb(), rb());
      end
      C_HALT: begin
        cyc(e, o, rb(), rb(), rb());
        m_halt = 1'b1;
        repeat (20) cyc(mk(3'd1), o, rb(), rb(), rb());
      end
      C_R, C_I: begin
        cyc(e, o, rb(), rb(), rb());
        e = mk(3'd6);
        e.ALUOp   = alu_code(o);
        e.ALUSrcB = (c == C_I);
        e.ALUSrcA = (o == 6'b011000);
        e.ExtSel  = (o == 6'b000010) || (o == 6'b011100);
        cyc(e, o, rb(), rb(), rb());
        e = mk(3'd7);
        e.RegWre    = 1'b1;
        e.WrRegDSrc = 1'b1;
        e.RegDst    = (c == C_I) ? 2'b01 : 2'b10;
        e.PCWre     = 1'b1;
        cyc(e, o, rb(), rb(), rb());
        m_ret++;
      end
      C_BR: begin
        cyc(e, o, rb(), rb(), rb());
        z  = (zf < 0) ? rb() : 1'(zf);
        s  = (sf < 0) ? rb() : 1'(sf);
        tk = (o == 6'b110000 && z) || (o == 6'b110001 && !z) ||
             (o == 6'b110010 && s);
        e = mk(3'd5);
        e.ALUOp = (o == 6'b110010) ? 3'd5 : 3'd1;
        e.PCWre = 1'b1;
        e.PCSrc = tk ? 2'b01 : 2'b00;
        cyc(e, o, z, s, rb());
        m_ret++;
      end
      default: begin
        cyc(e, o, rb(), rb(), rb());
        e = mk(3'd2);
        e.ALUSrcB = 1'b1;
        e.ExtSel  = 1'b1;
        cyc(e, o, rb(), rb(), rb());
        for (int i = 0; i <= waits; i++) begin
          e = mk(3'd3);
          e.mRD = (c == C_LW);
          e.mWR = (c == C_SW);
          e.PCWre = (c == C_SW) && (i == waits);
          cyc(e, o, rb(), rb(), i == waits);
        end
        if (c == C_LW) begin
          e = mk(3'd4);
          e.RegWre    = 1'b1;
          e.RegDst    = 2'b01;
          e.WrRegDSrc = 1'b1;
          e.DBDataSrc = 1'b1;
          e.PCWre     = 1'b1;
          cyc(e, o, rb(), rb(), rb());
        end
        m_ret++;
      end
    endcase
  endtask

  task automatic do_reset();
    exp_valid = 1'b0;
    RST_n     = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_retired", 32'(bus.retired), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    @(posedge CLK);
    #1;
    RST_n  = 1'b1;
    m_ret  = '0;
    m_halt = 1'b0;
  endtask

  logic [5:0] legal_ops [17];
  logic [5:0] r;

  initial begin
    legal_ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000,
                  6'b010001, 6'b010010, 6'b010011, 6'b011000,
                  6'b011100, 6'b100110, 6'b100111, 6'b110000,
                  6'b110001, 6'b110010, 6'b111000, 6'b111001,
                  6'b111010};
    exp_valid     = 1'b0;
    bus.op        = '0;
    bus.zero      = 1'b0;
    bus.sign      = 1'b0;
    bus.mem_ready = 1'b0;
    m_ret         = '0;
    m_halt        = 1'b0;
    RST_n         = 1'b0;
    #2;
    chk("init_state", 32'(bus.state), 32'd0);
    chk("init_mRD", 32'(bus.mRD), 32'd0);
    do_reset();

    exec(6'b000000, 0, -1, -1);
    chk("add_retired", 32'(bus.retired), 32'd1);
    exec(6'b100111, 3, -1, -1);
    exec(6'b110000, 0, 1, -1);
    exec(6'b110001, 0, 1, -1);
    chk("br_retired", 32'(bus.retired), 32'd4);
    exec(6'b111010, 0, -1, -1);
    exec(6'b110110, 0, -1, -1);
    chk("ill_retired", 32'(bus.retired), 32'd5);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do r = 6'($urandom_range(0, 63));
        while (classify(r) != C_BAD);
      end else begin
        r = legal_ops[$urandom_range(0, 16)];
      end
      exec(r, $urandom_range(0, 3), -1, -1);
    end

    do_reset();
    repeat (16) exec(6'b000000, 0, -1, -1);
    chk("wrap_retired", 32'(bus.retired), 32'd0);

    exec(6'b111111, 0, -1, -1);
    exp_valid = 1'b0;
    chk("halt_state", 32'(bus.state), 32'd1);
    chk("halt_flag", 32'(bus.halted), 32'd1);
    chk("halt_pcwre", 32'(bus.PCWre), 32'd0);
    do_reset();

    cyc(mk(3'd0) | exp_t'(1) << 21, 6'b100111, 0, 0, 0);
    exp_valid = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    chk("mid_mem_state", 32'(bus.state), 32'd3);
    chk("mid_mem_mrd", 32'(bus.mRD), 32'd1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("async_state", 32'(bus.state), 32'd0);
    chk("async_mrd", 32'(bus.mRD), 32'd0);
    chk("async_retired", 32'(bus.retired), 32'd0);
    @(posedge CLK);
    #1;
    RST_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
